// File: rtl/lmem_arbiter_pkg.sv
// Shared definitions for the layer-memory arbiter: csel layer codes, FSM state
// encoding, default memory widths and the pointer-width helper.
package lmem_arbiter_pkg;

  localparam int LMEM_AW = 12;
  localparam int LMEM_DW = 20;

  localparam logic [2:0] CSEL_L0_K0 = 3'd1;
  localparam logic [2:0] CSEL_L0_K1 = 3'd2;
  localparam logic [2:0] CSEL_L1_K0 = 3'd3;
  localparam logic [2:0] CSEL_L1_K1 = 3'd4;
  localparam logic [2:0] CSEL_L2    = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_LOCK   = 2'd2
  } arb_state_e;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lmem_rr_pick.sv
// Combinational NREQ-way round-robin picker: first valid & unmasked requester
// found searching upward from ptr, wrapping modulo NREQ.
module lmem_rr_pick
  import lmem_arbiter_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int PW   = ptr_width(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [PW-1:0]   ptr,
  input  logic [NREQ-1:0] mask,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   gnt_idx,
  output logic            any
);

  always_comb begin
    int          idx;
    logic [PW-1:0] ix;
    grant   = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    ix      = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      ix  = PW'(idx);
      if (!any && valid[ix] && mask[ix]) begin
        any       = 1'b1;
        grant[ix] = 1'b1;
        gnt_idx   = ix;
      end
    end
  end

endmodule

// File: rtl/lmem_arbiter.sv
// Layer-memory arbiter: round-robin access of NREQ requesters to one memory port,
// registered issue, read responses tagged back to their owner two cycles later.
// Optional requester lock enabled by macro LMEM_ARBITER_LOCK_EN.
module lmem_arbiter
  import lmem_arbiter_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = LMEM_AW,
  parameter int DW   = LMEM_DW
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef LMEM_ARBITER_LOCK_EN
  input  logic [NREQ-1:0]      req_lock,
`endif
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_we,
  input  logic [3*NREQ-1:0]    req_sel,
  input  logic [AW*NREQ-1:0]   req_addr,
  input  logic [DW*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [DW-1:0]        rsp_data,
  output logic                 cwr,
  output logic                 crd,
  output logic [AW-1:0]        caddr_wr,
  output logic [AW-1:0]        caddr_rd,
  output logic [DW-1:0]        cdata_wr,
  output logic [2:0]           csel,
  input  logic [DW-1:0]        cdata_rd,
  output logic                 arb_idle
);

  localparam int PW = ptr_width(NREQ);

  logic            cwr_q, cwr_d, crd_q, crd_d;
  logic [AW-1:0]   caddr_wr_q, caddr_wr_d, caddr_rd_q, caddr_rd_d;
  logic [DW-1:0]   cdata_wr_q, cdata_wr_d;
  logic [2:0]      csel_q, csel_d;
  logic [NREQ-1:0] rd_tag_q, rd_tag_d, rsp_valid_q, rsp_valid_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  arb_state_e      state_q, state_d;

  logic [NREQ-1:0] mask, grant;
  logic [PW-1:0]   gnt_idx;
  logic            any;

`ifdef LMEM_ARBITER_LOCK_EN
  logic [NREQ-1:0] lock_owner_q, lock_owner_d;
  assign mask = (state_q == ST_LOCK) ? lock_owner_q : '1;
`else
  assign mask = '1;
`endif

  lmem_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .valid   (req_valid),
    .ptr     (ptr_q),
    .mask    (mask),
    .grant   (grant),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  assign req_ready = grant;

  always_comb begin
    cwr_d       = 1'b0;
    crd_d       = 1'b0;
    caddr_wr_d  = caddr_wr_q;
    caddr_rd_d  = caddr_rd_q;
    cdata_wr_d  = cdata_wr_q;
    csel_d      = csel_q;
    rd_tag_d    = '0;
    rsp_valid_d = rd_tag_q;
    ptr_d       = ptr_q;
    // A read issued this cycle returns data next cycle, so stay active for it.
    state_d     = (any || crd_q) ? ST_ACTIVE : ST_IDLE;
    if (any) begin
      ptr_d  = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
      csel_d = req_sel[int'(gnt_idx)*3 +: 3];
      if (req_we[gnt_idx]) begin
        cwr_d      = 1'b1;
        caddr_wr_d = req_addr[int'(gnt_idx)*AW +: AW];
        cdata_wr_d = req_wdata[int'(gnt_idx)*DW +: DW];
      end else begin
        crd_d      = 1'b1;
        caddr_rd_d = req_addr[int'(gnt_idx)*AW +: AW];
        rd_tag_d   = grant;
      end
    end
`ifdef LMEM_ARBITER_LOCK_EN
    lock_owner_d = lock_owner_q;
    if (state_q == ST_LOCK && !any) state_d = ST_LOCK;
    if (any && req_lock[gnt_idx]) begin
      state_d      = ST_LOCK;
      lock_owner_d = grant;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cwr_q       <= 1'b0;
      crd_q       <= 1'b0;
      caddr_wr_q  <= '0;
      caddr_rd_q  <= '0;
      cdata_wr_q  <= '0;
      csel_q      <= '0;
      rd_tag_q    <= '0;
      rsp_valid_q <= '0;
      ptr_q       <= '0;
      state_q     <= ST_IDLE;
`ifdef LMEM_ARBITER_LOCK_EN
      lock_owner_q <= '0;
`endif
    end else begin
      cwr_q       <= cwr_d;
      crd_q       <= crd_d;
      caddr_wr_q  <= caddr_wr_d;
      caddr_rd_q  <= caddr_rd_d;
      cdata_wr_q  <= cdata_wr_d;
      csel_q      <= csel_d;
      rd_tag_q    <= rd_tag_d;
      rsp_valid_q <= rsp_valid_d;
      ptr_q       <= ptr_d;
      state_q     <= state_d;
`ifdef LMEM_ARBITER_LOCK_EN
      lock_owner_q <= lock_owner_d;
`endif
    end
  end

  assign cwr       = cwr_q;
  assign crd       = crd_q;
  assign caddr_wr  = caddr_wr_q;
  assign caddr_rd  = caddr_rd_q;
  assign cdata_wr  = cdata_wr_q;
  assign csel      = csel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = (|rsp_valid_q) ? cdata_rd : '0;
  assign arb_idle  = (state_q == ST_IDLE) && (req_valid == '0);

endmodule

// File: tb/tb_lmem_arbiter.sv
// Bench for lmem_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model with a synchronous-read memory alongside.
module tb_lmem_arbiter;
  import lmem_arbiter_pkg::*;

  localparam int NREQ = 3;
  localparam int AW   = 12;
  localparam int DW   = 20;

  logic                clk, reset;
  logic [NREQ-1:0]     req_valid, req_we, req_ready, rsp_valid;
  logic [3*NREQ-1:0]   req_sel;
  logic [AW*NREQ-1:0]  req_addr;
  logic [DW*NREQ-1:0]  req_wdata;
  logic [DW-1:0]       rsp_data, cdata_wr, cdata_rd;
  logic                cwr, crd, arb_idle;
  logic [AW-1:0]       caddr_wr, caddr_rd;
  logic [2:0]          csel;
`ifdef LMEM_ARBITER_LOCK_EN
  logic [NREQ-1:0]     req_lock;
`endif

  int checks = 0;
  int errors = 0;

  lmem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
`ifdef LMEM_ARBITER_LOCK_EN
    .req_lock(req_lock),
`endif
    .req_valid(req_valid), .req_we(req_we), .req_sel(req_sel),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .cwr(cwr), .crd(crd), .caddr_wr(caddr_wr), .caddr_rd(caddr_rd),
    .cdata_wr(cdata_wr), .csel(csel), .cdata_rd(cdata_rd), .arb_idle(arb_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Layer memory: synchronous read, data on cdata_rd the cycle after crd.
  logic [DW-1:0] mem [0:32767];
  always @(posedge clk) begin
    if (cwr) mem[{csel, caddr_wr}] <= cdata_wr;
    if (crd) cdata_rd <= mem[{csel, caddr_rd}];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic v, input logic we, input logic [2:0] sel,
                         input logic [AW-1:0] addr, input logic [DW-1:0] data);
    req_valid[r]          = v;
    req_we[r]             = we;
    req_sel[r*3 +: 3]     = sel;
    req_addr[r*AW +: AW]  = addr;
    req_wdata[r*DW +: DW] = data;
  endtask

  task automatic clear_all();
    req_valid = '0; req_we = '0; req_sel = '0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_all();
    tick(); tick();
    checks++; if (cwr !== 1'b0) begin errors++; $display("FAIL reset_cwr: got %0h expected 0", cwr); end
    checks++; if (crd !== 1'b0) begin errors++; $display("FAIL reset_crd: got %0h expected 0", crd); end
    checks++; if (caddr_wr !== '0) begin errors++; $display("FAIL reset_caddr_wr: got %0h expected 0", caddr_wr); end
    checks++; if (caddr_rd !== '0) begin errors++; $display("FAIL reset_caddr_rd: got %0h expected 0", caddr_rd); end
    checks++; if (cdata_wr !== '0) begin errors++; $display("FAIL reset_cdata_wr: got %0h expected 0", cdata_wr); end
    checks++; if (csel !== 3'd0) begin errors++; $display("FAIL reset_csel: got %0h expected 0", csel); end
    checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL reset_rsp_valid: got %0h expected 0", rsp_valid); end
    checks++; if (rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data: got %0h expected 0", rsp_data); end
    checks++; if (arb_idle !== 1'b1) begin errors++; $display("FAIL reset_arb_idle: got %0h expected 1", arb_idle); end
    reset = 1'b0;
    tick();
    checks++; if (arb_idle !== 1'b1) begin errors++; $display("FAIL post_reset_idle: got %0h expected 1", arb_idle); end
  endtask

  task automatic test_write_issue();
    set_req(0, 1'b1, 1'b1, CSEL_L0_K0, 12'h041, 20'h00ABC);
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL wr_ready: got %0b expected 001", req_ready); end
    tick();
    clear_all();
    checks++; if (cwr !== 1'b1 || crd !== 1'b0) begin errors++; $display("FAIL wr_strobes: got cwr=%0h crd=%0h expected 1/0", cwr, crd); end
    checks++; if (csel !== 3'd1) begin errors++; $display("FAIL wr_csel: got %0h expected 1", csel); end
    checks++; if (caddr_wr !== 12'h041) begin errors++; $display("FAIL wr_addr: got %0h expected 041", caddr_wr); end
    checks++; if (cdata_wr !== 20'h00ABC) begin errors++; $display("FAIL wr_data: got %0h expected 00abc", cdata_wr); end
    tick();
    checks++; if (cwr !== 1'b0) begin errors++; $display("FAIL wr_cwr_drop: got %0h expected 0", cwr); end
    checks++; if (caddr_wr !== 12'h041 || csel !== 3'd1) begin errors++; $display("FAIL wr_hold: got addr=%0h sel=%0h expected 041/1", caddr_wr, csel); end
  endtask

  task automatic test_round_robin();
    reset = 1'b1; clear_all(); tick(); reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      for (int r = 0; r < NREQ; r++) set_req(r, 1'b1, 1'b1, CSEL_L2, 12'(r*16 + k), 20'(k));
      #1;
      checks++; if (req_ready !== 3'(1 << (k % 3))) begin errors++; $display("FAIL rr_ready_%0d: got %0b expected %0b", k, req_ready, 3'(1 << (k % 3))); end
      tick();
      checks++; if (cwr !== 1'b1 || caddr_wr !== 12'((k % 3)*16 + k)) begin errors++; $display("FAIL rr_issue_%0d: got cwr=%0h addr=%0h expected 1/%0h", k, cwr, caddr_wr, 12'((k % 3)*16 + k)); end
    end
    clear_all();
    tick();
  endtask

  task automatic test_read();
    set_req(0, 1'b1, 1'b1, CSEL_L1_K0, 12'h005, 20'h12345);
    #1; tick(); clear_all(); tick();
    set_req(1, 1'b1, 1'b0, CSEL_L1_K0, 12'h005, 20'h0);
    #1;
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL rd_ready: got %0b expected 010", req_ready); end
    tick();
    clear_all();
    checks++; if (crd !== 1'b1 || cwr !== 1'b0 || caddr_rd !== 12'h005 || csel !== 3'd3) begin errors++; $display("FAIL rd_issue: got crd=%0h cwr=%0h addr=%0h sel=%0h expected 1/0/005/3", crd, cwr, caddr_rd, csel); end
    checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL rd_early_rsp: got %0b expected 000", rsp_valid); end
    tick();
    checks++; if (rsp_valid !== 3'b010 || rsp_data !== 20'h12345) begin errors++; $display("FAIL rd_rsp: got v=%0b d=%0h expected 010/12345", rsp_valid, rsp_data); end
    checks++; if (arb_idle !== 1'b0) begin errors++; $display("FAIL rd_busy: got %0h expected 0", arb_idle); end
    tick();
    checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL rd_rsp_drop: got %0b expected 000", rsp_valid); end
    checks++; if (arb_idle !== 1'b1) begin errors++; $display("FAIL rd_idle: got %0h expected 1", arb_idle); end
  endtask

  task automatic test_write_then_read();
    set_req(0, 1'b1, 1'b1, CSEL_L1_K0, 12'h010, 20'h7FFFF);
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL raw_wr_ready: got %0b expected 001", req_ready); end
    tick();
    clear_all();
    set_req(1, 1'b1, 1'b0, CSEL_L1_K0, 12'h010, 20'h0);
    #1;
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL raw_rd_ready: got %0b expected 010", req_ready); end
    tick();
    clear_all();
    tick();
    checks++; if (rsp_valid !== 3'b010 || rsp_data !== 20'h7FFFF) begin errors++; $display("FAIL raw_rsp: got v=%0b d=%0h expected 010/7ffff", rsp_valid, rsp_data); end
    tick();
  endtask

  task automatic test_reset_mid();
    set_req(2, 1'b1, 1'b0, CSEL_L1_K0, 12'h010, 20'h0);
    #1; tick();
    clear_all();
    reset = 1'b1;
    tick();
    checks++; if (rsp_valid !== '0 || rsp_data !== '0) begin errors++; $display("FAIL rst_mid_rsp: got v=%0b d=%0h expected 0/0", rsp_valid, rsp_data); end
    checks++; if (crd !== 1'b0 || cwr !== 1'b0 || caddr_rd !== '0 || caddr_wr !== '0 || cdata_wr !== '0 || csel !== '0) begin errors++; $display("FAIL rst_mid_outs: got crd=%0h cwr=%0h ard=%0h awr=%0h d=%0h sel=%0h expected all 0", crd, cwr, caddr_rd, caddr_wr, cdata_wr, csel); end
    checks++; if (arb_idle !== 1'b1) begin errors++; $display("FAIL rst_mid_idle: got %0h expected 1", arb_idle); end
    reset = 1'b0;
    tick();
    checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL rst_mid_after: got %0b expected 000", rsp_valid); end
  endtask

  typedef struct {
    bit v; logic we; logic [2:0] sel; logic [AW-1:0] addr; logic [DW-1:0] data;
    int owner; logic [DW-1:0] exp;
  } txn_t;

  task automatic test_random();
    logic [DW-1:0] ref_mem [int];
    bit pv [NREQ];
    logic pwe [NREQ];
    int pkey [NREQ];
    logic [DW-1:0] pdata [NREQ];
    txn_t a0, a1, a2;
    int ptr_m, g, key, idx;
    logic [2:0] last_sel;
    logic [AW-1:0] last_wa, last_ra;
    logic [DW-1:0] last_wd;
    logic [NREQ-1:0] exp_rdy, exp_rv;
    bit exp_idle;
    reset = 1'b1; clear_all(); tick(); reset = 1'b0;
    ptr_m = 0; last_sel = '0; last_wa = '0; last_ra = '0; last_wd = '0;
    a1 = '{default: '0}; a2 = '{default: '0};
    for (int r = 0; r < NREQ; r++) begin pv[r] = 0; pwe[r] = 0; pkey[r] = 0; pdata[r] = '0; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (a1.v) begin
        checks++; if (cwr !== a1.we || crd !== !a1.we || csel !== a1.sel) begin errors++; $display("FAIL rnd_issue c%0d: got cwr=%0h crd=%0h sel=%0h expected we=%0h sel=%0h", cyc, cwr, crd, csel, a1.we, a1.sel); end
        last_sel = a1.sel;
        if (a1.we) begin
          last_wa = a1.addr; last_wd = a1.data;
          checks++; if (caddr_wr !== a1.addr || cdata_wr !== a1.data) begin errors++; $display("FAIL rnd_wr c%0d: got %0h/%0h expected %0h/%0h", cyc, caddr_wr, cdata_wr, a1.addr, a1.data); end
        end else begin
          last_ra = a1.addr;
          checks++; if (caddr_rd !== a1.addr) begin errors++; $display("FAIL rnd_rd_addr c%0d: got %0h expected %0h", cyc, caddr_rd, a1.addr); end
        end
      end else begin
        checks++; if (cwr !== 1'b0 || crd !== 1'b0 || csel !== last_sel || caddr_wr !== last_wa || caddr_rd !== last_ra || cdata_wr !== last_wd) begin errors++; $display("FAIL rnd_hold c%0d: got cwr=%0h crd=%0h sel=%0h awr=%0h ard=%0h d=%0h", cyc, cwr, crd, csel, caddr_wr, caddr_rd, cdata_wr); end
      end
      exp_rv = (a2.v && !a2.we) ? 3'(1 << a2.owner) : 3'b000;
      checks++; if (rsp_valid !== exp_rv) begin errors++; $display("FAIL rnd_rsp_valid c%0d: got %0b expected %0b", cyc, rsp_valid, exp_rv); end
      if (exp_rv != 0) begin
        checks++; if (rsp_data !== a2.exp) begin errors++; $display("FAIL rnd_rsp_data c%0d: got %0h expected %0h", cyc, rsp_data, a2.exp); end
      end
      for (int r = 0; r < NREQ; r++) begin
        if (!pv[r] && $urandom_range(0, 1) == 1) begin
          key = int'($urandom_range(0, 39));
          pv[r] = 1; pkey[r] = key; pdata[r] = 20'($urandom);
          pwe[r] = ref_mem.exists(key) ? 1'($urandom_range(0, 1)) : 1'b1;
        end else if (pv[r] && $urandom_range(0, 7) == 0) begin
          pv[r] = 0;
        end
        set_req(r, pv[r], pwe[r], 3'(1 + pkey[r] / 8), 12'(12'h200 + pkey[r] % 8), pdata[r]);
      end
      #1;
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        idx = (ptr_m + k) % NREQ;
        if (g < 0 && pv[idx]) g = idx;
      end
      exp_rdy = (g >= 0) ? 3'(1 << g) : 3'b000;
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready c%0d: got %0b expected %0b", cyc, req_ready, exp_rdy); end
      exp_idle = !a1.v && !(a2.v && !a2.we) && (exp_rdy == 0) && !(pv[0] || pv[1] || pv[2]);
      checks++; if (arb_idle !== exp_idle) begin errors++; $display("FAIL rnd_idle c%0d: got %0h expected %0h", cyc, arb_idle, exp_idle); end
      a0 = '{default: '0};
      if (g >= 0) begin
        a0.v = 1; a0.we = pwe[g]; a0.sel = 3'(1 + pkey[g] / 8); a0.addr = 12'(12'h200 + pkey[g] % 8);
        a0.data = pdata[g]; a0.owner = g;
        if (pwe[g]) ref_mem[pkey[g]] = pdata[g];
        else a0.exp = ref_mem[pkey[g]];
        pv[g] = 0;
        ptr_m = (g + 1) % NREQ;
      end
      tick();
      a2 = a1; a1 = a0;
    end
    clear_all();
    tick(); tick();
  endtask

`ifdef LMEM_ARBITER_LOCK_EN
  task automatic test_lock();
    logic [NREQ-1:0] exp;
    reset = 1'b1; clear_all(); req_lock = '0; tick(); reset = 1'b0;
    set_req(1, 1'b1, 1'b1, CSEL_L0_K1, 12'h0, 20'h0);
    #1; tick(); clear_all();
    for (int k = 0; k < 5; k++) begin
      set_req(0, 1'b1, 1'b1, CSEL_L0_K0, 12'h300, 20'h1);
      set_req(1, 1'b1, 1'b1, CSEL_L0_K1, 12'h301, 20'h2);
      set_req(2, 1'b1, 1'b1, CSEL_L1_K1, 12'(12'h310 + k), 20'h3);
      req_lock = (k < 3) ? 3'b100 : 3'b000;
      #1;
      exp = (k < 4) ? 3'b100 : 3'b001;
      checks++; if (req_ready !== exp) begin errors++; $display("FAIL lock_ready_%0d: got %0b expected %0b", k, req_ready, exp); end
      tick();
    end
    clear_all(); req_lock = '0;
    tick();
  endtask
`endif

  initial begin
    reset = 1'b1;
    clear_all();
`ifdef LMEM_ARBITER_LOCK_EN
    req_lock = '0;
`endif
    test_reset();
    test_write_issue();
    test_round_robin();
    test_read();
    test_write_then_read();
    test_reset_mid();
    test_random();
`ifdef LMEM_ARBITER_LOCK_EN
    test_lock();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
